// File: rtl/row_window_buffer.sv
// ---------------------------------------------------------------------------
// row_window_buffer
//   Row-buffer bank for neighbourhood image processing.  Takes a raster pixel
//   stream and keeps the last K-1 rows in K-1 pixel-wide memories (one per
//   row).  Once K-1 complete rows are stored, every accepted pixel produces
//   one vertical K-pixel window column, one cycle later.
//
// Ports
//   clk        clock
//   rst_n      synchronous active-low reset
//   in_valid   pixel qualifier, one pixel per cycle, no backpressure
//   in_sof     start of frame (with in_valid): row 0 col 0, restarts frame
//   in_pixel   input pixel
//   out_valid  window column valid
//   out_col    K lanes of PIXEL_WIDTH; lane 0 = oldest row, lane K-1 = current
//   out_sol    with out_valid: column index 0
//   out_eol    with out_valid: column index IMG_WIDTH-1
//   primed     K-1 complete rows stored (RUN state)
// ---------------------------------------------------------------------------
module row_window_buffer #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int K           = 3,
    parameter int COL_W       = $clog2(IMG_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [PIXEL_WIDTH-1:0]   in_pixel,
    output logic                     out_valid,
    output logic [K*PIXEL_WIDTH-1:0] out_col,
    output logic                     out_sol,
    output logic                     out_eol,
    output logic                     primed
);

    localparam int NRB  = K - 1;
    localparam int RB_W = (NRB > 1) ? $clog2(NRB) : 1;
    localparam int RC_W = $clog2(K);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN} state_t;

    state_t                   state_q, state_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [RC_W-1:0]          row_cnt_q, row_cnt_d;
    logic [RB_W-1:0]          wr_rb_q, wr_rb_d;

    // Write pipeline: the pixel is written one cycle after its read was issued.
    logic                     wr_en_q, wr_en_d;
    logic [COL_W-1:0]         wr_addr_q, wr_addr_d;
    logic [RB_W-1:0]          wr_sel_q, wr_sel_d;
    logic [PIXEL_WIDTH-1:0]   wr_data_q, wr_data_d;

    // Output side, aligned with the registered RAM read data.
    logic                     out_valid_q, out_valid_d;
    logic [COL_W-1:0]         out_idx_q, out_idx_d;
    logic [RB_W-1:0]          lane_base_q, lane_base_d;
    logic [PIXEL_WIDTH-1:0]   cur_pix_q, cur_pix_d;

    logic                     rd_en;
    logic [COL_W-1:0]         rd_addr;
    logic                     col_wrap;
    logic [NRB*PIXEL_WIDTH-1:0] rd_bus;
    int                       lane_sel;

    assign col_wrap = (col_q == COL_W'(IMG_WIDTH - 1));
    assign rd_addr  = col_q;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_cnt_d   = row_cnt_q;
        wr_rb_d     = wr_rb_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = col_q;
        wr_sel_d    = wr_rb_q;
        wr_data_d   = in_pixel;
        out_valid_d = 1'b0;
        out_idx_d   = out_idx_q;
        lane_base_d = lane_base_q;
        cur_pix_d   = cur_pix_q;
        rd_en       = 1'b0;

        if (in_valid && in_sof) begin
            // Restart from any state; this pixel is row 0 col 0 and emits nothing.
            state_d   = ST_FILL;
            col_d     = COL_W'(1);
            row_cnt_d = '0;
            wr_rb_d   = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_sel_d  = '0;
        end else if (in_valid && state_q != ST_IDLE) begin
            wr_en_d = 1'b1;
            col_d   = col_wrap ? '0 : col_q + COL_W'(1);
            if (col_wrap) begin
                wr_rb_d = (wr_rb_q == RB_W'(NRB - 1)) ? '0 : wr_rb_q + RB_W'(1);
                if (row_cnt_q != RC_W'(K - 1)) begin
                    row_cnt_d = row_cnt_q + RC_W'(1);
                end
                if (state_q == ST_FILL && row_cnt_q == RC_W'(K - 2)) begin
                    state_d = ST_RUN;
                end
            end
            if (state_q == ST_RUN) begin
                // Read only when emitting so out_col holds across idle cycles.
                out_valid_d = 1'b1;
                rd_en       = 1'b1;
                out_idx_d   = col_q;
                lane_base_d = wr_rb_q;
                cur_pix_d   = in_pixel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_cnt_q   <= '0;
            wr_rb_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_sel_q    <= '0;
            wr_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            lane_base_q <= '0;
            cur_pix_q   <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_cnt_q   <= row_cnt_d;
            wr_rb_q     <= wr_rb_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_sel_q    <= wr_sel_d;
            wr_data_q   <= wr_data_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            lane_base_q <= lane_base_d;
            cur_pix_q   <= cur_pix_d;
        end
    end

    // One simple dual-port memory per stored row.  Write and read addresses
    // never coincide in a cycle (consecutive pixels use different columns).
    genvar gi;
    generate
        for (gi = 0; gi < NRB; gi++) begin : g_rb
            logic [PIXEL_WIDTH-1:0] mem [IMG_WIDTH];
            logic [PIXEL_WIDTH-1:0] rd_q;

            always_ff @(posedge clk) begin
                if (wr_en_q && wr_sel_q == RB_W'(gi)) begin
                    mem[wr_addr_q] <= wr_data_q;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_q <= '0;
                end else if (rd_en) begin
                    rd_q <= mem[rd_addr];
                end
            end

            assign rd_bus[gi*PIXEL_WIDTH +: PIXEL_WIDTH] = rd_q;
        end
    endgenerate

    // Buffer wr_rb holds the oldest row, so lanes rotate starting there.
    always_comb begin
        out_col  = '0;
        lane_sel = 0;
        for (int j = 0; j < NRB; j++) begin
            lane_sel = int'(lane_base_q) + j;
            if (lane_sel >= NRB) begin
                lane_sel = lane_sel - NRB;
            end
            out_col[j*PIXEL_WIDTH +: PIXEL_WIDTH] = rd_bus[lane_sel*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
        out_col[NRB*PIXEL_WIDTH +: PIXEL_WIDTH] = cur_pix_q;
    end

    assign out_valid = out_valid_q;
    assign out_sol   = out_valid_q && (out_idx_q == '0);
    assign out_eol   = out_valid_q && (out_idx_q == COL_W'(IMG_WIDTH - 1));
    assign primed    = (state_q == ST_RUN);

endmodule

// File: tb/tb_row_window_buffer.sv
// ---------------------------------------------------------------------------
// tb_row_window_buffer
//   Directed bench for row_window_buffer.  Instance A: K=3, IMG_WIDTH=4
//   (fill, rotation, gaps, mid-row restart, reset).  Instance B: K=5,
//   IMG_WIDTH=8 (deep window, end of line).  Pixels are row*16+col, with an
//   offset per frame so stale data from an earlier frame would be visible.
// ---------------------------------------------------------------------------
module tb_row_window_buffer;

    logic        clk;
    logic        rst_n;

    logic        a_valid, a_sof;
    logic [7:0]  a_pix;
    logic        a_out_valid, a_sol, a_eol, a_primed;
    logic [23:0] a_out_col;

    logic        b_valid, b_sof;
    logic [7:0]  b_pix;
    logic        b_out_valid, b_sol, b_eol, b_primed;
    logic [39:0] b_out_col;

    int check_cnt = 0;
    int error_cnt = 0;

    row_window_buffer #(.PIXEL_WIDTH(8), .IMG_WIDTH(4), .K(3)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_valid),
        .in_sof    (a_sof),
        .in_pixel  (a_pix),
        .out_valid (a_out_valid),
        .out_col   (a_out_col),
        .out_sol   (a_sol),
        .out_eol   (a_eol),
        .primed    (a_primed)
    );

    row_window_buffer #(.PIXEL_WIDTH(8), .IMG_WIDTH(8), .K(5)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_valid),
        .in_sof    (b_sof),
        .in_pixel  (b_pix),
        .out_valid (b_out_valid),
        .out_col   (b_out_col),
        .out_sol   (b_sol),
        .out_eol   (b_eol),
        .primed    (b_primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            error_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one input cycle to A; outputs are sampled 1 time unit after the edge.
    task automatic drive_a(input logic v, input logic s, input logic [7:0] p);
        a_valid = v;
        a_sof   = s;
        a_pix   = p;
        @(posedge clk);
        #1;
        $display("A v=%0d sof=%0d pix=%02h -> ov=%0d col=%06h sol=%0d eol=%0d primed=%0d",
                 v, s, p, a_out_valid, a_out_col, a_sol, a_eol, a_primed);
    endtask

    task automatic drive_b(input logic v, input logic s, input logic [7:0] p);
        b_valid = v;
        b_sof   = s;
        b_pix   = p;
        @(posedge clk);
        #1;
        $display("B v=%0d sof=%0d pix=%02h -> ov=%0d col=%010h sol=%0d eol=%0d primed=%0d",
                 v, s, p, b_out_valid, b_out_col, b_sol, b_eol, b_primed);
    endtask

    function automatic logic [23:0] col3(input logic [7:0] l0, input logic [7:0] l1,
                                         input logic [7:0] l2);
        return {l2, l1, l0};
    endfunction

    // Send rows first..last of an A frame (offset added to row*16+col);
    // no output may appear, primed rises only after the last column of row 1.
    task automatic fill_a(input logic [7:0] base, input int first_col);
        for (int r = 0; r < 2; r++) begin
            for (int c = (r == 0) ? first_col : 0; c < 4; c++) begin
                drive_a(1'b1, (r == 0 && c == 0), 8'(base + r*16 + c));
                check("fill_ov", a_out_valid, 1'b0);
                check("fill_primed", a_primed, (r == 1 && c == 3));
            end
        end
    endtask

    logic [23:0] held;

    initial begin
        rst_n = 1'b0;
        a_valid = 1'b0; a_sof = 1'b0; a_pix = '0;
        b_valid = 1'b0; b_sof = 1'b0; b_pix = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ov", a_out_valid, 1'b0);
        check("rst_primed", a_primed, 1'b0);
        check("rst_col", a_out_col, 24'h0);
        check("rst_sol_eol", {a_sol, a_eol}, 2'b00);
        check("rst_b_col", b_out_col, 40'h0);
        rst_n = 1'b1;

        // Pixels before the first sof are dropped.
        drive_a(1'b1, 1'b0, 8'hAA);
        check("idle_drop_ov", a_out_valid, 1'b0);

        // Rows 0-1 prime the buffers.
        fill_a(8'h00, 0);

        // Row 2 with a gap after every pixel.
        for (int c = 0; c < 4; c++) begin
            drive_a(1'b1, 1'b0, 8'(8'h20 + c));
            check("gap_ov", a_out_valid, 1'b1);
            check("gap_col", a_out_col, col3(8'(c), 8'(8'h10 + c), 8'(8'h20 + c)));
            check("gap_sol", a_sol, (c == 0));
            check("gap_eol", a_eol, (c == 3));
            held = a_out_col;
            drive_a(1'b0, 1'b0, 8'hEE);
            check("gap_idle_ov", a_out_valid, 1'b0);
            check("gap_idle_hold", a_out_col, held);
        end

        // Rows 3 and 4 continuous: buffer rotation.
        for (int r = 3; r <= 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                drive_a(1'b1, 1'b0, 8'(r*16 + c));
                check("rot_ov", a_out_valid, 1'b1);
                check("rot_col", a_out_col,
                      col3(8'((r-2)*16 + c), 8'((r-1)*16 + c), 8'(r*16 + c)));
            end
        end

        // Mid-row restart at row 5 col 2.
        drive_a(1'b1, 1'b0, 8'h50);
        drive_a(1'b1, 1'b0, 8'h51);
        check("pre_sof_col", a_out_col, col3(8'h31, 8'h41, 8'h51));
        drive_a(1'b1, 1'b1, 8'h80);
        check("sof_no_out", a_out_valid, 1'b0);
        check("sof_primed_drop", a_primed, 1'b0);
        fill_a(8'h80, 1);
        drive_a(1'b1, 1'b0, 8'hA0);
        check("new_frame_col", a_out_col, col3(8'h80, 8'h90, 8'hA0));
        check("new_frame_sol", a_sol, 1'b1);
        drive_a(1'b1, 1'b0, 8'hA1);
        drive_a(1'b1, 1'b0, 8'hA2);
        drive_a(1'b1, 1'b0, 8'hA3);
        check("new_frame_eol_col", a_out_col, col3(8'h83, 8'h93, 8'hA3));
        check("new_frame_eol", a_eol, 1'b1);

        // Reset for one cycle during row 3.
        drive_a(1'b1, 1'b0, 8'hB0);
        drive_a(1'b1, 1'b0, 8'hB1);
        rst_n = 1'b0;
        drive_a(1'b1, 1'b0, 8'hB2);
        check("mid_rst_ov", a_out_valid, 1'b0);
        check("mid_rst_primed", a_primed, 1'b0);
        check("mid_rst_col", a_out_col, 24'h0);
        check("mid_rst_sol_eol", {a_sol, a_eol}, 2'b00);
        rst_n = 1'b1;
        drive_a(1'b1, 1'b0, 8'hB3);
        check("post_rst_drop", a_out_valid, 1'b0);
        drive_a(1'b1, 1'b0, 8'hB4);
        check("post_rst_drop_primed", a_primed, 1'b0);
        fill_a(8'h40, 0);
        drive_a(1'b1, 1'b0, 8'h60);
        check("reprime_ov", a_out_valid, 1'b1);
        check("reprime_col", a_out_col, col3(8'h40, 8'h50, 8'h60));
        drive_a(1'b0, 1'b0, 8'h00);

        // Instance B: K=5, IMG_WIDTH=8.
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 8; c++) begin
                drive_b(1'b1, (r == 0 && c == 0), 8'(r*16 + c));
                if (r == 3 && c == 7) begin
                    check("b_fill_ov", b_out_valid, 1'b0);
                    check("b_primed", b_primed, 1'b1);
                end
                if (r == 4 && c == 0) begin
                    check("b_sol_col", b_out_col, {8'h40, 8'h30, 8'h20, 8'h10, 8'h00});
                    check("b_sol", b_sol, 1'b1);
                end
            end
        end
        check("b_eol_ov", b_out_valid, 1'b1);
        check("b_eol_col", b_out_col, {8'h47, 8'h37, 8'h27, 8'h17, 8'h07});
        check("b_eol", b_eol, 1'b1);
        drive_b(1'b0, 1'b0, 8'h00);
        check("b_idle_ov", b_out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", error_cnt, check_cnt);
        $finish;
    end

endmodule
